// File: rtl/pe_vec_mac.sv
// Streaming vector MAC: dot product of up to NUM_DATA streamed samples with a
// preloaded coefficient bank, saturated to PE_OUT_WIDTH and held until consumed.
module pe_vec_mac #(
    parameter int FILTER_WIDTH = 8,
    parameter int INPUT_WIDTH  = 8,
    parameter int PE_OUT_WIDTH = 24,
    parameter int NUM_DATA     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             w_load,
    input  logic [FILTER_WIDTH*NUM_DATA-1:0] w_data,
    input  logic                             start,
    input  logic [$clog2(NUM_DATA)-1:0]      len_m1,
    input  logic                             signed_mode,
    input  logic                             in_valid,
    input  logic [INPUT_WIDTH-1:0]           in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [PE_OUT_WIDTH-1:0]          out_data,
    output logic                             out_sat,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int CW        = $clog2(NUM_DATA);
    localparam int ACC_WIDTH = FILTER_WIDTH + INPUT_WIDTH + CW;
    // Saturation compares in a signed domain wide enough for both the sum and the unsigned ceiling
    localparam int SW        = ((ACC_WIDTH > PE_OUT_WIDTH) ? ACC_WIDTH : PE_OUT_WIDTH) + 1;

    localparam logic signed [SW-1:0] ONE_SW   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] SAT_SMAX = (ONE_SW <<< (PE_OUT_WIDTH - 1)) - ONE_SW;
    localparam logic signed [SW-1:0] SAT_SMIN = -(ONE_SW <<< (PE_OUT_WIDTH - 1));
    localparam logic signed [SW-1:0] SAT_UMAX = (ONE_SW <<< PE_OUT_WIDTH) - ONE_SW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Returns {clipped, value}; the sum is interpreted per the latched operand mode.
    function automatic logic [PE_OUT_WIDTH:0] saturate(input logic [ACC_WIDTH-1:0] v,
                                                       input logic              sm);
        logic signed [SW-1:0] x;
        logic [PE_OUT_WIDTH:0] r;
        if (sm) begin
            x = {{(SW-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
            if (x > SAT_SMAX) begin
                r = {1'b1, SAT_SMAX[PE_OUT_WIDTH-1:0]};
            end else if (x < SAT_SMIN) begin
                r = {1'b1, SAT_SMIN[PE_OUT_WIDTH-1:0]};
            end else begin
                r = {1'b0, x[PE_OUT_WIDTH-1:0]};
            end
        end else begin
            x = {{(SW-ACC_WIDTH){1'b0}}, v};
            if (x > SAT_UMAX) begin
                r = {1'b1, SAT_UMAX[PE_OUT_WIDTH-1:0]};
            end else begin
                r = {1'b0, x[PE_OUT_WIDTH-1:0]};
            end
        end
        return r;
    endfunction

    logic [1:0]              state_r;
    logic [FILTER_WIDTH-1:0] coef_r [NUM_DATA];
    logic [CW-1:0]           idx_r;
    logic [CW-1:0]           len_r;
    logic                    mode_r;
    logic                    prod_vld_r;
    logic [ACC_WIDTH-1:0]    acc_r;
    logic [ACC_WIDTH-1:0]    prod_r;
    logic                    out_valid_r;
    logic                    out_sat_r;
    logic [PE_OUT_WIDTH-1:0] out_data_r;

    logic                    accept_s;
    logic                    last_s;
    logic [ACC_WIDTH-1:0]    x_ext_s;
    logic [ACC_WIDTH-1:0]    c_ext_s;
    logic [ACC_WIDTH-1:0]    prod_s;
    logic [ACC_WIDTH-1:0]    sum_s;
    logic [PE_OUT_WIDTH:0]   sat_s;

    // Operand extension, product, running sum and saturated result
    always_comb begin
        if (mode_r) begin
            x_ext_s = {{(ACC_WIDTH-INPUT_WIDTH){in_data[INPUT_WIDTH-1]}}, in_data};
            c_ext_s = {{(ACC_WIDTH-FILTER_WIDTH){coef_r[idx_r][FILTER_WIDTH-1]}}, coef_r[idx_r]};
        end else begin
            x_ext_s = {{(ACC_WIDTH-INPUT_WIDTH){1'b0}}, in_data};
            c_ext_s = {{(ACC_WIDTH-FILTER_WIDTH){1'b0}}, coef_r[idx_r]};
        end
        // Low ACC_WIDTH bits of the product are exact in both modes (two's complement)
        prod_s   = x_ext_s * c_ext_s;
        sum_s    = acc_r + (prod_vld_r ? prod_r : {ACC_WIDTH{1'b0}});
        sat_s    = saturate(sum_s, mode_r);
        accept_s = (state_r == ST_RUN) && in_valid;
        last_s   = (idx_r == len_r);
    end

    // Coefficient bank, writable only while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_DATA; k++) begin
                coef_r[k] <= {FILTER_WIDTH{1'b0}};
            end
        end else if ((state_r == ST_IDLE) && w_load) begin
            for (int k = 0; k < NUM_DATA; k++) begin
                coef_r[k] <= w_data[k*FILTER_WIDTH +: FILTER_WIDTH];
            end
        end
    end

    // Control FSM, accumulation datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= {CW{1'b0}};
            len_r       <= {CW{1'b0}};
            mode_r      <= 1'b0;
            prod_vld_r  <= 1'b0;
            acc_r       <= {ACC_WIDTH{1'b0}};
            prod_r      <= {ACC_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_sat_r   <= 1'b0;
            out_data_r  <= {PE_OUT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r      <= {ACC_WIDTH{1'b0}};
                        idx_r      <= {CW{1'b0}};
                        prod_vld_r <= 1'b0;
                        len_r      <= len_m1;
                        mode_r     <= signed_mode;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_r <= sum_s;
                    if (accept_s) begin
                        prod_r     <= prod_s;
                        prod_vld_r <= 1'b1;
                        // idx stops at the last position so it never wraps within a run
                        if (last_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            idx_r <= idx_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        prod_vld_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    acc_r       <= sum_s;
                    prod_vld_r  <= 1'b0;
                    out_data_r  <= sat_s[PE_OUT_WIDTH-1:0];
                    out_sat_r   <= sat_s[PE_OUT_WIDTH];
                    out_valid_r <= 1'b1;
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_RUN);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

endmodule
